// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED polarity constants and brightness helper
package led_pkg;

  localparam int N_LED = 8;
  localparam logic LED_ON  = 1'b0;
  localparam logic LED_OFF = 1'b1;

  function automatic int maxb(input int pwm_w);
    return (1 << pwm_w) - 1;
  endfunction

endpackage

// File: rtl/led_pwm_chan.sv
// rtl/led_pwm_chan.sv - one LED channel: brightness register, linear decay, PWM compare
module led_pwm_chan
  import led_pkg::*;
#(
  parameter int PWM_W      = 6,
  parameter int DECAY_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fade_en,
  input  logic             lit_n,
  input  logic             tick,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             out_n
);

  localparam logic [PWM_W-1:0] MAXB = PWM_W'(maxb(PWM_W));
  localparam logic [PWM_W-1:0] STEP = PWM_W'(DECAY_STEP);

  logic [PWM_W-1:0] bright;
  logic [PWM_W-1:0] bright_dec;

  // Clamp at zero instead of wrapping so a tail never flashes back to full.
  assign bright_dec = (bright > STEP) ? (bright - STEP) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      bright <= '0;
      out_n  <= LED_OFF;
    end else begin
      out_n <= (bright > pwm_cnt) ? LED_ON : LED_OFF;
      if (lit_n == LED_ON)
        bright <= MAXB;
      else if (!fade_en)
        bright <= '0;
      else if (tick)
        bright <= bright_dec;
    end
  end

endmodule

// File: rtl/led_fade_pwm.sv
// rtl/led_fade_pwm.sv - LED driver with comet-tail PWM fade-out of released LEDs
module led_fade_pwm
  import led_pkg::*;
#(
  parameter int N_LED      = led_pkg::N_LED,
  parameter int PWM_W      = 6,
  parameter int DECAY_DIV  = 50000,
  parameter int DECAY_STEP = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fade_en,
  input  logic [N_LED-1:0] pat_in,
  output logic [N_LED-1:0] out
);

  localparam int PRESC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(DECAY_DIV - 1);
  localparam logic [PWM_W-1:0]   PWM_LAST  = PWM_W'(maxb(PWM_W) - 1);

  logic [N_LED-1:0]   pat_q;
  logic [PRESC_W-1:0] presc;
  logic [PRESC_W-1:0] presc_nxt;
  logic               tick;
  logic [PWM_W-1:0]   pwm_cnt;

  assign presc_nxt = (presc == PRESC_MAX) ? '0 : presc + PRESC_W'(1);

  // tick is registered from presc_nxt so it is high exactly while presc sits at its last value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_q   <= {N_LED{LED_OFF}};
      presc   <= '0;
      tick    <= 1'b0;
      pwm_cnt <= '0;
    end else begin
      pat_q   <= pat_in;
      presc   <= presc_nxt;
      tick    <= (presc_nxt == PRESC_MAX);
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + PWM_W'(1);
    end
  end

  for (genvar i = 0; i < N_LED; i++) begin : g_chan
    led_pwm_chan #(
      .PWM_W      (PWM_W),
      .DECAY_STEP (DECAY_STEP)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .fade_en (fade_en),
      .lit_n   (pat_q[i]),
      .tick    (tick),
      .pwm_cnt (pwm_cnt),
      .out_n   (out[i])
    );
  end

endmodule
